ahb_bus_arbiter: RTL and testbench

Two-master to one-slave arbiter for the MCU core's AHB-lite-like bus. It shares a single system bus between the instruction-fetch port and the data port (`dbusif`). It passes address/control from the winning master in the address phase and tracks which master owns the data phase. A master that loses arbitration has its address phase captured into a one-entry holding buffer and is stalled through its own `hready` until the buffered transfer completes. It sits between the core bus interfaces and the system interconnect/decoder.

---
 rtl/ahb_bus_arbiter.sv | 162 ++++++++++++++++
 tb/tb_ahb_bus_arbiter.sv | 334 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ahb_bus_arbiter.sv
// Two-master (instruction fetch, data) to one-slave AHB-lite arbiter with a one-entry
// holding buffer per master. Define AHB_BUS_ARBITER_RR_EN for round-robin on ties (default D>I).
module ahb_bus_arbiter (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] i_haddr,
  input  logic        i_hprot,
  input  logic [1:0]  i_hsize,
  input  logic        i_hwrite,
  input  logic [31:0] i_hwdata,
  input  logic        i_htrans,
  input  logic [31:0] d_haddr,
  input  logic        d_hprot,
  input  logic [1:0]  d_hsize,
  input  logic        d_hwrite,
  input  logic [31:0] d_hwdata,
  input  logic        d_htrans,
  output logic [31:0] i_hrdata,
  output logic        i_hresp,
  output logic        i_hready,
  output logic [31:0] d_hrdata,
  output logic        d_hresp,
  output logic        d_hready,
  output logic [31:0] s_haddr,
  output logic        s_hprot,
  output logic [1:0]  s_hsize,
  output logic        s_hwrite,
  output logic        s_htrans,
  output logic [31:0] s_hwdata,
  input  logic [31:0] s_hrdata,
  input  logic        s_hresp,
  input  logic        s_hready
);

  typedef enum logic [1:0] {OwnNone = 2'd0, OwnI = 2'd1, OwnD = 2'd2} own_e;

  own_e        own_q, own_d;
  logic        pend_i_q, pend_i_d, pend_d_q, pend_d_d;
  logic [31:0] ibuf_addr_q, dbuf_addr_q;
  logic        ibuf_prot_q, dbuf_prot_q;
  logic [1:0]  ibuf_size_q, dbuf_size_q;
  logic        ibuf_write_q, dbuf_write_q;

  logic        live_i, live_d, eff_i, eff_d, grant_i, grant_d, cap_i, cap_d;
  logic [31:0] ei_addr, ed_addr;
  logic        ei_prot, ed_prot, ei_write, ed_write;
  logic [1:0]  ei_size, ed_size;

`ifdef AHB_BUS_ARBITER_RR_EN
  logic last_d_q;  // 1 when D received the most recent grant
`endif

  always_comb begin
    // A buffered master is stalled, so it can never present a live request.
    i_hready = (own_q == OwnI) ? s_hready : ~pend_i_q;
    d_hready = (own_q == OwnD) ? s_hready : ~pend_d_q;
    i_hresp  = (own_q == OwnI) ? s_hresp : 1'b0;
    d_hresp  = (own_q == OwnD) ? s_hresp : 1'b0;
    i_hrdata = s_hrdata;
    d_hrdata = s_hrdata;

    live_i = i_htrans & i_hready;
    live_d = d_htrans & d_hready;
    eff_i  = pend_i_q | live_i;
    eff_d  = pend_d_q | live_d;

    ei_addr  = pend_i_q ? ibuf_addr_q  : i_haddr;
    ei_prot  = pend_i_q ? ibuf_prot_q  : i_hprot;
    ei_size  = pend_i_q ? ibuf_size_q  : i_hsize;
    ei_write = pend_i_q ? ibuf_write_q : i_hwrite;
    ed_addr  = pend_d_q ? dbuf_addr_q  : d_haddr;
    ed_prot  = pend_d_q ? dbuf_prot_q  : d_hprot;
    ed_size  = pend_d_q ? dbuf_size_q  : d_hsize;
    ed_write = pend_d_q ? dbuf_write_q : d_hwrite;

`ifdef AHB_BUS_ARBITER_RR_EN
    grant_d = (eff_i & eff_d) ? ~last_d_q : eff_d;
`else
    grant_d = eff_d;
`endif
    grant_i = eff_i & ~grant_d;

    s_htrans = grant_i | grant_d;
    s_haddr  = 32'd0;
    s_hprot  = 1'b0;
    s_hsize  = 2'd0;
    s_hwrite = 1'b0;
    if (grant_d) begin
      s_haddr  = ed_addr;
      s_hprot  = ed_prot;
      s_hsize  = ed_size;
      s_hwrite = ed_write;
    end else if (grant_i) begin
      s_haddr  = ei_addr;
      s_hprot  = ei_prot;
      s_hsize  = ei_size;
      s_hwrite = ei_write;
    end

    unique case (own_q)
      OwnI:    s_hwdata = i_hwdata;
      OwnD:    s_hwdata = d_hwdata;
      default: s_hwdata = 32'd0;
    endcase

    // Accepted by the master but not by the slave this cycle: hold it.
    cap_i    = live_i & ~(grant_i & s_hready);
    cap_d    = live_d & ~(grant_d & s_hready);
    pend_i_d = cap_i | (pend_i_q & ~(grant_i & s_hready));
    pend_d_d = cap_d | (pend_d_q & ~(grant_d & s_hready));

    own_d = own_q;
    if (s_hready) begin
      if (grant_d)      own_d = OwnD;
      else if (grant_i) own_d = OwnI;
      else              own_d = OwnNone;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      own_q        <= OwnNone;
      pend_i_q     <= 1'b0;
      pend_d_q     <= 1'b0;
      ibuf_addr_q  <= 32'd0;
      ibuf_prot_q  <= 1'b0;
      ibuf_size_q  <= 2'd0;
      ibuf_write_q <= 1'b0;
      dbuf_addr_q  <= 32'd0;
      dbuf_prot_q  <= 1'b0;
      dbuf_size_q  <= 2'd0;
      dbuf_write_q <= 1'b0;
    end else begin
      own_q    <= own_d;
      pend_i_q <= pend_i_d;
      pend_d_q <= pend_d_d;
      if (cap_i) begin
        ibuf_addr_q  <= i_haddr;
        ibuf_prot_q  <= i_hprot;
        ibuf_size_q  <= i_hsize;
        ibuf_write_q <= i_hwrite;
      end
      if (cap_d) begin
        dbuf_addr_q  <= d_haddr;
        dbuf_prot_q  <= d_hprot;
        dbuf_size_q  <= d_hsize;
        dbuf_write_q <= d_hwrite;
      end
    end
  end

`ifdef AHB_BUS_ARBITER_RR_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      last_d_q <= 1'b0;
    end else if (s_hready && (grant_i || grant_d)) begin
      last_d_q <= grant_d;
    end
  end
`endif

endmodule

// File: tb/tb_ahb_bus_arbiter.sv
// Self-checking bench for ahb_bus_arbiter: directed literal cases plus randomized traffic
// checked every cycle against a transfer-level model with per-master order scoreboards.
module tb_ahb_bus_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] i_haddr, d_haddr, i_hwdata, d_hwdata, s_hrdata;
  logic        i_hprot, d_hprot, i_hwrite, d_hwrite, i_htrans, d_htrans;
  logic [1:0]  i_hsize, d_hsize;
  logic [31:0] i_hrdata, d_hrdata, s_haddr, s_hwdata;
  logic        i_hresp, d_hresp, i_hready, d_hready;
  logic        s_hprot, s_hwrite, s_htrans, s_hresp, s_hready;
  logic [1:0]  s_hsize;

  always #5 clk = ~clk;

  ahb_bus_arbiter dut (
    .clk(clk), .rst(rst),
    .i_haddr(i_haddr), .i_hprot(i_hprot), .i_hsize(i_hsize), .i_hwrite(i_hwrite),
    .i_hwdata(i_hwdata), .i_htrans(i_htrans),
    .d_haddr(d_haddr), .d_hprot(d_hprot), .d_hsize(d_hsize), .d_hwrite(d_hwrite),
    .d_hwdata(d_hwdata), .d_htrans(d_htrans),
    .i_hrdata(i_hrdata), .i_hresp(i_hresp), .i_hready(i_hready),
    .d_hrdata(d_hrdata), .d_hresp(d_hresp), .d_hready(d_hready),
    .s_haddr(s_haddr), .s_hprot(s_hprot), .s_hsize(s_hsize), .s_hwrite(s_hwrite),
    .s_htrans(s_htrans), .s_hwdata(s_hwdata),
    .s_hrdata(s_hrdata), .s_hresp(s_hresp), .s_hready(s_hready)
  );

  int n_vec = 0;
  int n_err = 0;

  // Model state: index 0 = instruction master, 1 = data master; owner -1 = none.
  bit          m_pend[2];
  logic [31:0] m_baddr[2];
  bit          m_bprot[2];
  logic [1:0]  m_bsize[2];
  bit          m_bwrite[2];
  int          m_own = -1;
  int          m_last = 0;
  bit          n_pend[2];
  logic [31:0] n_baddr[2];
  bit          n_bprot[2];
  logic [1:0]  n_bsize[2];
  bit          n_bwrite[2];
  int          n_own;
  int          n_last;
  logic [31:0] q_i[$];
  logic [31:0] q_d[$];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s at %0t: got %h, expected %h", nm, $time, act, exp);
    end
  endtask

  task automatic model_check();
    bit          htr[2], hr[2], live[2], eff[2], prt[2], wr[2];
    logic [31:0] ad[2], hw[2], ea[2];
    logic [1:0]  sz[2];
    bit          ep[2], ew[2];
    logic [1:0]  es[2];
    logic [31:0] front;
    int          win;
    htr = '{i_htrans, d_htrans};
    ad  = '{i_haddr, d_haddr};
    prt = '{i_hprot, d_hprot};
    sz  = '{i_hsize, d_hsize};
    wr  = '{i_hwrite, d_hwrite};
    hw  = '{i_hwdata, d_hwdata};
    for (int m = 0; m < 2; m++) begin
      hr[m]   = (m_own == m) ? s_hready : !m_pend[m];
      live[m] = htr[m] && hr[m];
      eff[m]  = m_pend[m] || live[m];
      ea[m]   = m_pend[m] ? m_baddr[m] : ad[m];
      ep[m]   = m_pend[m] ? m_bprot[m] : prt[m];
      es[m]   = m_pend[m] ? m_bsize[m] : sz[m];
      ew[m]   = m_pend[m] ? m_bwrite[m] : wr[m];
    end
    win = -1;
    if (eff[0] && eff[1]) begin
`ifdef AHB_BUS_ARBITER_RR_EN
      win = (m_last == 1) ? 0 : 1;
`else
      win = 1;
`endif
    end else if (eff[1]) win = 1;
    else if (eff[0]) win = 0;

    chk("i_hready", {31'd0, i_hready}, {31'd0, hr[0]});
    chk("d_hready", {31'd0, d_hready}, {31'd0, hr[1]});
    chk("s_htrans", {31'd0, s_htrans}, {31'd0, win >= 0});
    chk("s_haddr", s_haddr, (win >= 0) ? ea[win] : 32'd0);
    chk("s_hprot", {31'd0, s_hprot}, {31'd0, (win >= 0) ? ep[win] : 1'b0});
    chk("s_hsize", {30'd0, s_hsize}, {30'd0, (win >= 0) ? es[win] : 2'd0});
    chk("s_hwrite", {31'd0, s_hwrite}, {31'd0, (win >= 0) ? ew[win] : 1'b0});
    chk("s_hwdata", s_hwdata, (m_own >= 0) ? hw[m_own] : 32'd0);
    chk("i_hresp", {31'd0, i_hresp}, {31'd0, (m_own == 0) ? s_hresp : 1'b0});
    chk("d_hresp", {31'd0, d_hresp}, {31'd0, (m_own == 1) ? s_hresp : 1'b0});
    chk("i_hrdata", i_hrdata, s_hrdata);
    chk("d_hrdata", d_hrdata, s_hrdata);

    // Order scoreboard: each accepted address must reach the slave once, in order.
    if (!rst) begin
      if (live[0]) q_i.push_back(ad[0]);
      if (live[1]) q_d.push_back(ad[1]);
      if (s_hready && win >= 0) begin
        if (win == 0 ? q_i.size() == 0 : q_d.size() == 0) begin
          chk("issue_without_accept", s_haddr, 32'hDEAD_BEEF);
        end else begin
          front = (win == 0) ? q_i.pop_front() : q_d.pop_front();
          chk("order", s_haddr, front);
        end
      end
    end

    n_own  = (s_hready) ? win : m_own;
    n_last = (s_hready && win >= 0) ? win : m_last;
    for (int m = 0; m < 2; m++) begin
      n_pend[m]   = m_pend[m];
      n_baddr[m]  = m_baddr[m];
      n_bprot[m]  = m_bprot[m];
      n_bsize[m]  = m_bsize[m];
      n_bwrite[m] = m_bwrite[m];
      if (m_pend[m] && win == m && s_hready) n_pend[m] = 1'b0;
      if (live[m] && !(win == m && s_hready)) begin
        n_pend[m]   = 1'b1;
        n_baddr[m]  = ad[m];
        n_bprot[m]  = prt[m];
        n_bsize[m]  = sz[m];
        n_bwrite[m] = wr[m];
      end
    end
    if (rst) begin
      n_own  = -1;
      n_last = 0;
      n_pend = '{1'b0, 1'b0};
      q_i.delete();
      q_d.delete();
    end
  endtask

  task automatic settle();
    @(negedge clk);
    model_check();
  endtask

  task automatic advance();
    @(posedge clk);
    m_pend   = n_pend;
    m_baddr  = n_baddr;
    m_bprot  = n_bprot;
    m_bsize  = n_bsize;
    m_bwrite = n_bwrite;
    m_own    = n_own;
    m_last   = n_last;
    #1;
  endtask

  task automatic idle();
    i_haddr = 0; i_hprot = 0; i_hsize = 0; i_hwrite = 0; i_hwdata = 0; i_htrans = 0;
    d_haddr = 0; d_hprot = 0; d_hsize = 0; d_hwrite = 0; d_hwdata = 0; d_htrans = 0;
    s_hrdata = 0; s_hresp = 0; s_hready = 1;
  endtask

  task automatic do_reset();
    idle();
    rst = 1;
    settle();
    advance();
    rst = 0;
  endtask

  logic [31:0] seen[4];
  logic [31:0] want[4];

  initial begin
    idle();
    rst = 1;
    @(posedge clk);
    #1;
    rst = 0;

    // Reset state
    settle();
    chk("rst_s_htrans", {31'd0, s_htrans}, 32'd0);
    chk("rst_s_haddr", s_haddr, 32'd0);
    chk("rst_s_hwdata", s_hwdata, 32'd0);
    chk("rst_i_hready", {31'd0, i_hready}, 32'd1);
    chk("rst_d_hready", {31'd0, d_hready}, 32'd1);
    chk("rst_hresp", {30'd0, i_hresp, d_hresp}, 32'd0);
    advance();

    // Uncontended D read
    d_htrans = 1; d_haddr = 32'h2000_0010; d_hprot = 1;
    settle();
    chk("unc_s_haddr", s_haddr, 32'h2000_0010);
    chk("unc_s_htrans", {31'd0, s_htrans}, 32'd1);
    chk("unc_i_hready0", {31'd0, i_hready}, 32'd1);
    advance();
    idle();
    s_hrdata = 32'hA5A5_0001;
    settle();
    chk("unc_d_hready", {31'd0, d_hready}, 32'd1);
    chk("unc_d_hrdata", d_hrdata, 32'hA5A5_0001);
    chk("unc_i_hready1", {31'd0, i_hready}, 32'd1);
    advance();

    // Simultaneous I and D
    do_reset();
    i_htrans = 1; i_haddr = 32'h0000_0100;
    d_htrans = 1; d_haddr = 32'h2000_0000;
    settle();
    chk("sim_c0_addr", s_haddr, 32'h2000_0000);
    advance();
    idle();
    settle();
    chk("sim_c1_addr", s_haddr, 32'h0000_0100);
    chk("sim_c1_i_hready", {31'd0, i_hready}, 32'd0);
    advance();
    s_hrdata = 32'h1234_5678;
    settle();
    chk("sim_c2_i_hready", {31'd0, i_hready}, 32'd1);
    chk("sim_c2_i_hrdata", i_hrdata, 32'h1234_5678);
    advance();

    // Continuous contention: round-robin alternates, fixed priority starves I
    do_reset();
`ifdef AHB_BUS_ARBITER_RR_EN
    want = '{32'h2000_0000, 32'h0000_0100, 32'h2000_0000, 32'h0000_0100};
`else
    want = '{32'h2000_0000, 32'h2000_0000, 32'h2000_0000, 32'h2000_0000};
`endif
    for (int k = 0; k < 4; k++) begin
      i_htrans = 1; i_haddr = 32'h0000_0100;
      d_htrans = 1; d_haddr = 32'h2000_0000;
      settle();
      seen[k] = s_haddr;
      chk("contend_order", seen[k], want[k]);
      advance();
    end
    idle();
    for (int k = 0; k < 3; k++) begin
      settle();
      advance();
    end

    // D data phase stretched two cycles while I requests
    do_reset();
    d_htrans = 1; d_haddr = 32'h2000_0040;
    settle();
    advance();
    idle();
    s_hready = 0; i_htrans = 1; i_haddr = 32'h0000_0300;
    settle();
    chk("wait_d_hready0", {31'd0, d_hready}, 32'd0);
    advance();
    idle();
    s_hready = 0;
    settle();
    chk("wait_d_hready1", {31'd0, d_hready}, 32'd0);
    chk("wait_i_stalled", {31'd0, i_hready}, 32'd0);
    advance();
    idle();
    settle();
    chk("wait_d_hready2", {31'd0, d_hready}, 32'd1);
    chk("wait_i_issue", s_haddr, 32'h0000_0300);
    chk("wait_i_htrans", {31'd0, s_htrans}, 32'd1);
    advance();
    settle();
    chk("wait_i_done", {31'd0, i_hready}, 32'd1);
    advance();

    // Error routing to I data phase
    do_reset();
    i_htrans = 1; i_haddr = 32'h0000_0400;
    settle();
    advance();
    idle();
    s_hresp = 1;
    settle();
    chk("err_i_hresp", {31'd0, i_hresp}, 32'd1);
    chk("err_d_hresp", {31'd0, d_hresp}, 32'd0);
    advance();

    // Reset with I buffered and D owning the data phase
    do_reset();
    i_htrans = 1; i_haddr = 32'h0000_0500;
    d_htrans = 1; d_haddr = 32'h2000_0500;
    settle();
    advance();
    idle();
    rst = 1;
    settle();
    advance();
    rst = 0;
    settle();
    chk("rmid_s_htrans", {31'd0, s_htrans}, 32'd0);
    chk("rmid_i_hready", {31'd0, i_hready}, 32'd1);
    chk("rmid_d_hready", {31'd0, d_hready}, 32'd1);
    advance();
    settle();
    chk("rmid_no_replay", {31'd0, s_htrans}, 32'd0);
    advance();

    // Randomized traffic
    for (int c = 0; c < 4000; c++) begin
      rst      = ($urandom_range(249) == 0);
      i_htrans = 1'($urandom_range(1));
      d_htrans = 1'($urandom_range(1));
      i_haddr  = $urandom;
      d_haddr  = $urandom;
      i_hprot  = 1'($urandom_range(1));
      d_hprot  = 1'($urandom_range(1));
      i_hsize  = 2'($urandom_range(3));
      d_hsize  = 2'($urandom_range(3));
      i_hwrite = 1'($urandom_range(1));
      d_hwrite = 1'($urandom_range(1));
      i_hwdata = $urandom;
      d_hwdata = $urandom;
      s_hrdata = $urandom;
      s_hresp  = ($urandom_range(7) == 0);
      s_hready = ($urandom_range(3) != 0);
      settle();
      advance();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
